// File: rtl/gsm_pkg.sv
// Shared definitions for the GSM modem response parser: ASCII codes,
// receive FSM state encoding and the response match strings.
package gsm_pkg;

  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_GT = 8'h3E;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_9  = 8'h39;

  // Number of leading line bytes the classifier looks at (longest match string).
  localparam int HEAD_LEN     = 10;
  localparam int CMGS_PFX_LEN = 7;

  // Match strings, first character in the most significant byte.
  localparam logic [15:0] STR_OK    = "OK";
  localparam logic [39:0] STR_ERROR = "ERROR";
  localparam logic [79:0] STR_CMS   = "+CMS ERROR";
  localparam logic [55:0] STR_CMGS  = "+CMGS: ";

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LINE     = 2'd1,
    ST_CLASSIFY = 2'd2
  } gsm_rx_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASC_0) && (b <= ASC_9);
  endfunction

endpackage

// File: rtl/gsm_dec_acc.sv
// Saturating decimal accumulator: acc = acc*10 + digit per valid digit,
// clamped at 255 so the 8-bit result never wraps.
module gsm_dec_acc
  import gsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       dig_vld,
  input  logic [3:0] dig,
  output logic [7:0] result
);

  logic [9:0]  acc_q;
  logic [11:0] acc_next;

  // Next value before saturation; acc_q never exceeds 255 so 12 bits cover it.
  always_comb begin
    acc_next = ({2'b00, acc_q} * 12'd10) + {8'd0, dig};
  end

  // Accumulator register with clear and saturation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (dig_vld) begin
      if (acc_next > 12'd255) acc_q <= 10'd255;
      else                    acc_q <= acc_next[9:0];
    end
  end

  assign result = acc_q[7:0];

endmodule

// File: rtl/gsm_resp_parser.sv
// GSM modem response parser: assembles UART bytes into lines and reports
// OK / ERROR / +CMS ERROR / +CMGS: <n> lines and the "> " prompt as pulses.
// Optional inter-byte timeout enabled by defining GSM_RESP_TIMEOUT_EN.
// MAX_LEN must be at least 10 so the longest match string fits the buffer.
//
// state       | meaning
// ------------+------------------------------------------------
// ST_IDLE     | no bytes held
// ST_LINE     | accumulating a line
// ST_CLASSIFY | one cycle, evaluates the completed line
module gsm_resp_parser
  import gsm_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 90_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       ok_pulse,
  output logic       error_pulse,
  output logic       prompt_pulse,
  output logic       cmgs_pulse,
  output logic [7:0] cmgs_ref,
  output logic       timeout_pulse,
  output logic       busy
);

  localparam int            LW      = $clog2(MAX_LEN + 2);
  localparam logic [LW-1:0] LEN_OVF = LW'(MAX_LEN + 1);

  gsm_rx_state_t state_q, state_nxt;

  logic [7:0]             buf_q [MAX_LEN];
  logic [LW-1:0]          len_q;
  logic                   ovf;
  logic                   is_cr, is_lf, data_byte;
  logic                   prompt_hit, line_start, line_store, line_tmo;
  logic [8*HEAD_LEN-1:0]  head;
  logic                   pfx_cmgs, in_dig_zone, dig_vld, dig_close;
  logic                   dig_open_q, has_dig_q;
  logic                   cls_ok, cls_err, cls_cmgs;
  logic                   ok_set, err_set, prm_set, cmgs_set, tmo_set;
  logic [7:0]             acc_res;

  assign is_cr     = (rx_data == ASC_CR);
  assign is_lf     = (rx_data == ASC_LF);
  assign data_byte = rx_done && !is_cr && !is_lf;
  assign ovf       = (len_q == LEN_OVF);
  assign busy      = (state_q != ST_IDLE);

  // A byte arriving in CLASSIFY starts the next line just like in IDLE.
  assign line_start = (state_q != ST_LINE) && data_byte;
  assign prompt_hit = (state_q == ST_LINE) && data_byte && (len_q == LW'(1)) &&
                      (buf_q[0] == ASC_GT) && (rx_data == ASC_SP);
  assign line_store = (state_q == ST_LINE) && data_byte && !prompt_hit;

  // Leading bytes of the line packed first-character-high for string compares.
  always_comb begin
    head = '0;
    for (int i = 0; i < HEAD_LEN; i++) begin
      head[8*(HEAD_LEN-1-i) +: 8] = buf_q[i];
    end
  end

  // Digit field of a +CMGS line is decoded on the fly once the prefix is held.
  assign pfx_cmgs    = (head[8*HEAD_LEN-1 -: 8*CMGS_PFX_LEN] == STR_CMGS);
  assign in_dig_zone = line_store && (len_q >= LW'(CMGS_PFX_LEN)) && pfx_cmgs && dig_open_q;
  assign dig_vld     = in_dig_zone && is_digit(rx_data);
  assign dig_close   = in_dig_zone && !is_digit(rx_data);

  assign cls_ok   = !ovf && (len_q == LW'(2)) && (head[8*HEAD_LEN-1 -: 16] == STR_OK);
  assign cls_err  = !ovf && (((len_q == LW'(5)) && (head[8*HEAD_LEN-1 -: 40] == STR_ERROR)) ||
                             ((len_q >= LW'(10)) && (head == STR_CMS)));
  assign cls_cmgs = !ovf && has_dig_q && pfx_cmgs;

  gsm_dec_acc u_dec_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (line_start),
    .dig_vld (dig_vld),
    .dig     (rx_data[3:0]),
    .result  (acc_res)
  );

`ifdef GSM_RESP_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_cnt_q;

  // Inter-byte down-counter: reloads on every byte and outside LINE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt_q <= TMO_LOAD;
    end else if (rx_done || (state_q != ST_LINE)) begin
      tmo_cnt_q <= TMO_LOAD;
    end else if (tmo_cnt_q != '0) begin
      tmo_cnt_q <= tmo_cnt_q - 1'b1;
    end
  end

  // A byte in the expiry cycle wins over the timeout.
  assign line_tmo = (state_q == ST_LINE) && !rx_done && (tmo_cnt_q == '0);
`else
  assign line_tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (data_byte) state_nxt = ST_LINE;
      end
      ST_LINE: begin
        if (rx_done && is_lf) state_nxt = ST_CLASSIFY;
        else if (prompt_hit)  state_nxt = ST_IDLE;
        else if (line_tmo)    state_nxt = ST_IDLE;
      end
      ST_CLASSIFY: begin
        state_nxt = data_byte ? ST_LINE : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: which pulse fires next cycle, highest-priority class first.
  always_comb begin
    ok_set   = 1'b0;
    err_set  = 1'b0;
    prm_set  = 1'b0;
    cmgs_set = 1'b0;
    tmo_set  = 1'b0;
    case (state_q)
      ST_LINE: begin
        prm_set = prompt_hit;
        tmo_set = line_tmo;
      end
      ST_CLASSIFY: begin
        if (cls_ok)        ok_set   = 1'b1;
        else if (cls_err)  err_set  = 1'b1;
        else if (cls_cmgs) cmgs_set = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered pulses; cmgs_ref captures the accumulator with cmgs_pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ok_pulse      <= 1'b0;
      error_pulse   <= 1'b0;
      prompt_pulse  <= 1'b0;
      cmgs_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
      cmgs_ref      <= 8'd0;
    end else begin
      ok_pulse      <= ok_set;
      error_pulse   <= err_set;
      prompt_pulse  <= prm_set;
      cmgs_pulse    <= cmgs_set;
      timeout_pulse <= tmo_set;
      if (cmgs_set) cmgs_ref <= acc_res;
    end
  end

  // Line length and digit-field tracking; len saturates at MAX_LEN+1 (overflow).
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q      <= '0;
      dig_open_q <= 1'b1;
      has_dig_q  <= 1'b0;
    end else if (line_start) begin
      len_q      <= LW'(1);
      dig_open_q <= 1'b1;
      has_dig_q  <= 1'b0;
    end else if (line_store) begin
      if (len_q != LEN_OVF) len_q <= len_q + 1'b1;
      if (dig_vld)          has_dig_q  <= 1'b1;
      if (dig_close)        dig_open_q <= 1'b0;
    end else if (state_nxt == ST_IDLE) begin
      len_q <= '0;
    end
  end

  // Line buffer; bytes beyond MAX_LEN are counted but not stored.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((line_start && (i == 0)) || (line_store && (len_q == LW'(i)))) begin
        buf_q[i] <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_gsm_resp_parser.sv
// Scoreboard bench for gsm_resp_parser: stimulus pushes expected pulses,
// a monitor pops and compares them whenever any pulse output is high.
module tb_gsm_resp_parser;
  import gsm_pkg::*;

  localparam int TC = 100;

  localparam logic [4:0] K_NONE = 5'b00000;
  localparam logic [4:0] K_OK   = 5'b10000;
  localparam logic [4:0] K_ERR  = 5'b01000;
  localparam logic [4:0] K_PRM  = 5'b00100;
  localparam logic [4:0] K_CMGS = 5'b00010;
  localparam logic [4:0] K_TMO  = 5'b00001;

  typedef struct {
    logic [4:0] kind;
    logic [7:0] rf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_done = 1'b0;
  logic       ok_pulse, error_pulse, prompt_pulse, cmgs_pulse, timeout_pulse, busy;
  logic [7:0] cmgs_ref;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  exp_t       sb[$];
  logic [7:0] exp_ref = 8'd0;
  logic [4:0] mon_p;
  exp_t       mon_e;

  gsm_resp_parser #(.MAX_LEN(16), .TIMEOUT_CYC(TC)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_done       (rx_done),
    .ok_pulse      (ok_pulse),
    .error_pulse   (error_pulse),
    .prompt_pulse  (prompt_pulse),
    .cmgs_pulse    (cmgs_pulse),
    .cmgs_ref      (cmgs_ref),
    .timeout_pulse (timeout_pulse),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    mon_p = {ok_pulse, error_pulse, prompt_pulse, cmgs_pulse, timeout_pulse};
    if ($countones(mon_p) > 1) begin
      n_chk++;
      n_fail++;
      $display("FAIL onehot: pulses=%b (cycle %0d)", mon_p, cyc);
    end
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missed_pulse: kind=%b due cycle %0d not seen", mon_e.kind, mon_e.cyc);
    end
    if (mon_p != 5'b0) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: pulses=%b ref=%0d at cycle %0d", mon_p, cmgs_ref, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", int'(mon_p), int'(mon_e.kind));
        chk("pulse_cycle", cyc, mon_e.cyc);
        chk("cmgs_ref", int'(cmgs_ref), int'(mon_e.rf));
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_exp(input logic [4:0] kind, input int due);
    exp_t e;
    e.kind = kind;
    e.rf   = exp_ref;
    e.cyc  = due;
    sb.push_back(e);
  endtask

  // Sends a line; the pulse is expected two cycles after the LF strobe.
  task automatic send_line(input string s, input logic [4:0] kind, input logic [7:0] ref_v);
    logic [7:0] b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      if (b == ASC_LF && kind != K_NONE) begin
        if (kind == K_CMGS) exp_ref = ref_v;
        push_exp(kind, cyc + 2);
      end
      send(b, 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);

    chk("rst_pulses", int'({ok_pulse, error_pulse, prompt_pulse, cmgs_pulse, timeout_pulse}), 0);
    chk("rst_cmgs_ref", int'(cmgs_ref), 0);
    chk("rst_busy", int'(busy), 0);

    send_line("OK\r\n", K_OK, 8'd0);
    idle(3);
    chk("busy_after_ok", int'(busy), 0);

    send_line("+CMGS: 123\r\n", K_CMGS, 8'd123);
    send_line("+CMGS: 999\r\n", K_CMGS, 8'd255);
    send_line("+CMGS: 42A7\r\n", K_CMGS, 8'd42);
    send_line("+CMGS: \r\n", K_NONE, 8'd0);

    // Prompt: pulse one cycle after the space strobe, no LF needed.
    send(ASC_GT, 1);
    push_exp(K_PRM, cyc + 1);
    send(ASC_SP, 1);
    idle(2);
    chk("busy_after_prompt", int'(busy), 0);

    send_line("ERROR\r\n", K_ERR, 8'd0);
    send_line("+CMS ERROR: 500\r\n", K_ERR, 8'd0);
    send_line("+CMS ERROR 12345\r\n", K_ERR, 8'd0);
    send_line("+CMS ERROR 123456\r\n", K_NONE, 8'd0);
    send_line("AT+CMGF=1\r\n", K_NONE, 8'd0);
    send_line("ABCDEFGHIJKLMNOPQRST\r\n", K_NONE, 8'd0);
    send_line("OKX\r\n", K_NONE, 8'd0);
    send_line("\r\n", K_NONE, 8'd0);
    idle(3);
    chk("busy_after_junk", int'(busy), 0);

    // Next line starts in the CLASSIFY cycle.
    send(8'h4F, 1);
    send(8'h4B, 1);
    push_exp(K_OK, cyc + 2);
    send(ASC_LF, 0);
    send_line("OK\r\n", K_OK, 8'd0);
    idle(3);

    // Partial line followed by a long idle gap.
`ifdef GSM_RESP_TIMEOUT_EN
    push_exp(K_TMO, cyc + TC + 1);
    send(8'h4F, 1);
    idle(150);
    chk("busy_after_timeout", int'(busy), 0);
    send_line("K\r\n", K_NONE, 8'd0);
`else
    send(8'h4F, 1);
    idle(150);
    chk("busy_held", int'(busy), 1);
    send_line("K\r\n", K_OK, 8'd0);
`endif
    idle(3);

    // Reset mid-line drops the partial line and clears cmgs_ref.
    send(8'h4F, 1);
    send(8'h4B, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_ref = 8'd0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cmgs_ref", int'(cmgs_ref), 0);
    chk("midrst_pulses", int'({ok_pulse, error_pulse, prompt_pulse, cmgs_pulse, timeout_pulse}), 0);
    send_line("\r\n", K_NONE, 8'd0);
    idle(5);
    chk("midrst_busy_end", int'(busy), 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
